vend_timebase_ctrl: RTL
=======================

// Module: vend_timebase_ctrl
// PURPOSE
// - Sequences the vending machine timebase: runs the 25-bit prescaler against its terminal count,
//   emits a 1-cycle 2 Hz tick, and schedules a one-shot tick-counted timer for the vend FSM
//   (dispense hold, coin-return timeout, display blink). Sits between the board clock and the vend FSM.
// PARAMETERS
// - TC          25_000_000  prescaler terminal count; tick period = TC clk cycles (2 Hz at 50 MHz)
// - CNT_W       25          prescaler width; must satisfy 2**CNT_W >= TC
// - TMR_W       8           timer length width, in ticks
// - SYNC_START  1           1: accepted tmr_start clears prescaler (exact duration); 0: free-running
// PORTS
// - clk        in   1      system clock
// - rst        in   1      asynchronous, active-high reset
// - en         in   1      prescaler enable; low freezes prescaler, no ticks
// - tmr_start  in   1      1-cycle request to start timer
// - tmr_len    in   TMR_W  timer length in ticks, sampled with tmr_start
// - tmr_abort  in   1      cancel running timer, no done
// - tick_2hz   out  1      1-cycle pulse per prescaler wrap
// - blink      out  1      toggles on every tick (1 Hz square at defaults)
// - tmr_busy   out  1      high while timer in RUN
// - tmr_done   out  1      1-cycle pulse on timer expiry
// BEHAVIOUR
// - Reset (async assert, sync release): cnt=0, tick_2hz=0, blink=0, state=IDLE, rem=0, tmr_busy=0, tmr_done=0.
// - Prescaler: en=1 -> cnt increments; cnt==TC-1 -> cnt<=0 and tick_2hz<=1 on same edge; else tick_2hz<=0.
//   en=0 -> cnt holds, tick_2hz<=0. Terminal compare is equality on full CNT_W bits; cnt never exceeds TC-1.
// - blink <= ~blink on each edge where tick_2hz<=1. All outputs registered.
// - Timer FSM states: IDLE, RUN, DONE (enum in package).
//   IDLE: tmr_abort -> stay IDLE (abort beats start). tmr_start & tmr_len!=0 -> RUN, rem<=tmr_len,
//         cnt<=0 if SYNC_START. tmr_start & tmr_len==0 -> DONE (done pulse next cycle, busy never high).
//   RUN:  tmr_abort -> IDLE, no done (abort beats tick). tick_2hz==1 -> rem==1 ? DONE : rem<=rem-1.
//         tmr_start ignored (no restart, no queueing).
//   DONE: one cycle, tmr_done=1, -> IDLE unconditionally; start in DONE ignored.
// - tmr_busy = (state==RUN); tmr_done = (state==DONE); both decoded from registered state.
// - Latency (SYNC_START=1, en=1): start sampled at edge 0 -> tmr_busy high after edge 0; tmr_done high
//   for the cycle after edge len*TC+1; IDLE after edge len*TC+2. SYNC_START=0: first tick partial,
//   duration in ((len-1)*TC, len*TC] cycles + 1.
// - en=0 during RUN: timer pauses (no ticks), rem holds; resumes on en=1.
// - SYNC_START prescaler clear has priority over the normal increment/wrap; no tick on that edge.
// - rst mid-run: immediate return to IDLE, no done pulse on release.
// STRUCTURE
// - Package vend_pkg: TC_2HZ=25_000_000, CNT_W=25, tmr_state_t {IDLE,RUN,DONE}, default TMR_W.
// - Sub-module tc_prescaler (TC, CNT_W): counter + terminal-count equality + clear/enable,
//   outputs registered tick. Top holds FSM, rem counter, blink.
// TESTING (bench uses TC=4, TMR_W=4, SYNC_START=1 unless noted)
// - Reset then en=1 for 20 cycles -> tick_2hz pulses after edges 4,8,12,16,20; blink toggles each.
// - start, len=3 at edge 0 -> busy high edges 1..13, done single pulse after edge 13, IDLE after 14.
// - start len=0 -> done pulse after next edge, busy stays 0.
// - start len=5, abort at edge 9 -> busy drops after edge 9, done never asserted.
// - start len=2, en=0 for 6 cycles mid-run -> done delayed by exactly 6 cycles vs. baseline.
// - Same-cycle start+abort in IDLE -> stays IDLE; start while RUN -> rem unchanged;
//   rst asserted mid-RUN -> all outputs 0 asynchronously, no done after release.

Source files
------------

// File: rtl/vend_pkg.sv
// vend_pkg: shared timebase constants and timer state encoding
package vend_pkg;
  localparam int TC_2HZ = 25_000_000;
  localparam int CNT_W = 25;
  localparam int TMR_W = 8;
  typedef enum logic [1:0] {IDLE, RUN, DONE} tmr_state_t;
endpackage

// File: rtl/vend_timebase_ctrl_if.sv
// vend_timebase_ctrl_if: control/status bundle between vend FSM and timebase
interface vend_timebase_ctrl_if #(parameter int TMR_W = vend_pkg::TMR_W) ();
  logic en;
  logic tmr_start;
  logic [TMR_W-1:0] tmr_len;
  logic tmr_abort;
  logic tick_2hz;
  logic blink;
  logic tmr_busy;
  logic tmr_done;
  modport master (output en, tmr_start, tmr_len, tmr_abort, input tick_2hz, blink, tmr_busy, tmr_done);
  modport slave (input en, tmr_start, tmr_len, tmr_abort, output tick_2hz, blink, tmr_busy, tmr_done);
endinterface

// File: rtl/tc_prescaler.sv
// tc_prescaler: terminal-count prescaler with clear/enable and registered tick
module tc_prescaler #(
  parameter int TC = vend_pkg::TC_2HZ,
  parameter int CNT_W = vend_pkg::CNT_W
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic tick_d_o
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TC - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic tick_q, tick_d;
  // clear wins over wrap so a synchronised start never produces a tick
  assign tick_d = en_i && !clr_i && cnt_q == LAST;
  assign cnt_d = (clr_i || tick_d) ? '0 : en_i ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tick_q <= tick_d;
    end
  end
  assign tick_o = tick_q;
  assign tick_d_o = tick_d;
endmodule

// File: rtl/vend_timebase_ctrl.sv
// vend_timebase_ctrl: 2 Hz tick, blink and one-shot tick-counted timer for the vend FSM
module vend_timebase_ctrl #(
  parameter int TC = vend_pkg::TC_2HZ,
  parameter int CNT_W = vend_pkg::CNT_W,
  parameter int TMR_W = vend_pkg::TMR_W,
  parameter bit SYNC_START = 1'b1
) (
  input logic clk,
  input logic rst,
  vend_timebase_ctrl_if.slave bus
);
  import vend_pkg::*;
  tmr_state_t state_q, state_d;
  logic [TMR_W-1:0] rem_q, rem_d;
  logic blink_q, tick, tick_d, clr;
  assign clr = SYNC_START && state_q == IDLE && bus.tmr_start && !bus.tmr_abort && bus.tmr_len != '0;
  tc_prescaler #(.TC(TC), .CNT_W(CNT_W)) u_presc (
    .clk(clk),
    .rst(rst),
    .en_i(bus.en),
    .clr_i(clr),
    .tick_o(tick),
    .tick_d_o(tick_d)
  );
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    case (state_q)
      IDLE: if (bus.tmr_start && !bus.tmr_abort) begin
        state_d = bus.tmr_len != '0 ? RUN : DONE;
        rem_d = bus.tmr_len;
      end
      RUN: if (bus.tmr_abort) state_d = IDLE;
        else if (tick) begin
          state_d = rem_q == TMR_W'(1) ? DONE : RUN;
          rem_d = rem_q - 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      rem_q <= '0;
      blink_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q <= rem_d;
      blink_q <= blink_q ^ tick_d;
    end
  end
  assign bus.tick_2hz = tick;
  assign bus.blink = blink_q;
  assign bus.tmr_busy = state_q == RUN;
  assign bus.tmr_done = state_q == DONE;
endmodule
